ifu_fetch_engine: RTL and testbench
===================================

Name: ifu_fetch_engine

Overview:
- Initiator side of the IFU memory read interface: drives ifu_rd_req/ifu_rd_addr and captures ifu_rd_data.
- Holds the fetch PC and prefetches instructions into a small FIFO, tagging each word with its address.
- Presents instructions to decode through a valid/ready handshake.
- Supports a flush/redirect from execute for JMP/JMS/skip/ISZ.

Parameters:
- FIFO_DEPTH, 4, prefetch queue entries (power of two, >=2)
- RESET_PC, 'o200, fetch address loaded on reset
- ADDR_W, `ADDR_WIDTH, address width (12)
- DATA_W, `DATA_WIDTH, instruction width (12)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active low
- ifu_rd_req  out  1  memory read request, one word per asserted cycle
- ifu_rd_addr  out  ADDR_W  read address, valid when ifu_rd_req=1
- ifu_rd_data  in  DATA_W  read data, valid exactly one cycle after the request cycle
- redirect_valid  in  1  execute requests a flush and a new PC
- redirect_pc  in  ADDR_W  new fetch address
- fetch_halt  in  1  stop issuing new requests (HLT); in-flight data is still accepted
- dec_valid  out  1  head-of-queue instruction available
- dec_ready  in  1  decode accepts the head this cycle
- dec_instr  out  DATA_W  instruction word at the head
- dec_pc  out  ADDR_W  address of dec_instr
- dec_opcode  out  3  dec_instr[DATA_W-1:DATA_W-3], convenience decode

Behaviour:
- Reset (rst_n=0 at posedge):
  - pc=RESET_PC; FIFO empty; inflight=0.
  - Outputs: ifu_rd_req=0, ifu_rd_addr=0, dec_valid=0, dec_instr=0, dec_pc=0.
- Memory latency is fixed at 1 cycle. A request asserted in cycle N returns data on ifu_rd_data in cycle N+1, captured at the end of N+1. Back-to-back requests are legal every cycle.
- Issue rule: ifu_rd_req=1 when rst_n=1, !fetch_halt, !redirect_valid, and (count + inflight) < FIFO_DEPTH.
  - count is the FIFO occupancy after this cycle's pop.
  - ifu_rd_addr = pc. On issue, pc <= pc+1, wrapping mod 2^ADDR_W ('o7777 -> 'o0000).
- Request address registration: ifu_rd_req and ifu_rd_addr are combinational from registered state (pc, count, inflight), so the memory samples them at the same posedge. The issued address is latched into inflight_pc alongside inflight<=1.
- Response: when inflight=1 and no flush, push {inflight_pc, ifu_rd_data} into the FIFO at the end of the response cycle.
- Credit guarantee: the issue rule ensures a slot always exists for a response. An overflow is a design bug and fires an assertion.
- Decode handshake:
  - dec_valid = !empty; dec_instr/dec_pc/dec_opcode come from the head entry.
  - Pop when dec_valid && dec_ready.
  - The head is stable while dec_valid && !dec_ready.
- Simultaneous push and pop in the same cycle is legal at any occupancy, including full and empty.
  - Empty + push: no same-cycle bypass; data is visible at dec_valid the next cycle.
- Redirect (redirect_valid=1 at posedge):
  - FIFO cleared; pc <= redirect_pc; any inflight response is discarded (inflight cleared, ifu_rd_data ignored); no request that cycle; any pop that cycle is void.
  - The first request to redirect_pc is issued in the next cycle.
  - Redirect has priority over push, pop and halt.
- Halt: while fetch_halt=1, no new requests are issued. Inflight data still lands and decode still drains. Deasserting halt resumes at the current pc.
- Reset mid-operation: identical to power-on reset; any response arriving the cycle after reset is dropped.
- Pointers: rd_ptr/wr_ptr are $clog2(FIFO_DEPTH) bits and wrap naturally; count is $clog2(FIFO_DEPTH)+1 bits.

Decomposition:
- Package ifu_pkg: typedefs addr_t, word_t, fetch_entry_t {addr_t pc; word_t instr;}, constant RESET_PC_DEFAULT='o200, localparam OPC_MSB=DATA_W-1.
- One sub-module: ifu_fetch_fifo. Parameterized sync FIFO of fetch_entry_t with push/pop/flush/count, same clock and reset.
- The FSM is implicit: RUN / HALTED / REDIRECT_BUBBLE, encoded as an enum in ifu_pkg.

Test Plan:
- Reset, then dec_ready=1 with memory returning addr+1 as data -> requests to 'o200,'o201,'o202 on consecutive cycles; first dec_valid 2 cycles after reset deassertion with dec_pc='o200, dec_instr='o201.
- dec_ready=0 held -> exactly 4 requests issued ('o200–'o203), then ifu_rd_req stays 0; dec_instr holds the 'o200 entry; raising dec_ready resumes issue the same cycle.
- pc preset via redirect to 'o7776 -> fetched dec_pc sequence 'o7776,'o7777,'o0000 (wrap).
- Redirect to 'o1234 in the cycle after a request to 'o205 -> the 'o205 response is discarded, FIFO empty, next request addr='o1234, next dec_pc='o1234.
- fetch_halt=1 with one request in flight -> that word is enqueued, no further ifu_rd_req; halt released -> fetch resumes at the next sequential pc.
- rst_n=0 for one cycle with a full FIFO and a request in flight -> dec_valid=0 next cycle, stale response dropped, first request is 'o200.

Source files
------------

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
//   addr_t / word_t   : default 12-bit address and instruction word
//   fetch_entry_t     : prefetch queue entry {pc, instr}
//   fetch_state_e     : coarse fetch state (run / halted / redirect bubble)
//   opcode_of()       : top three bits of an instruction word
package ifu_pkg;

  localparam int unsigned IFU_ADDR_W = 12;
  localparam int unsigned IFU_DATA_W = 12;

  typedef logic [IFU_ADDR_W-1:0] addr_t;
  typedef logic [IFU_DATA_W-1:0] word_t;

  typedef struct packed {
    addr_t pc;
    word_t instr;
  } fetch_entry_t;

  localparam addr_t       RESET_PC_DEFAULT = 12'o200;
  localparam int unsigned OPC_MSB          = IFU_DATA_W - 1;

  typedef enum logic [1:0] {
    StRun,
    StHalted,
    StRedirBubble
  } fetch_state_e;

  function automatic logic [2:0] opcode_of(word_t w);
    return w[OPC_MSB -: 3];
  endfunction

endpackage

// File: rtl/ifu_fetch_engine_if.sv
// ifu_fetch_engine_if: bundles the memory read bus and the decode handshake.
//   ifu_rd_req/ifu_rd_addr : fetch -> memory, one word per asserted cycle
//   ifu_rd_data            : memory -> fetch, valid one cycle after request
//   dec_valid/dec_instr/dec_pc/dec_opcode : fetch -> decode head entry
//   dec_ready              : decode -> fetch, accepts the head this cycle
// Modports: master = fetch engine side, slave = memory/decode side.
interface ifu_fetch_engine_if
  import ifu_pkg::*;
#(
  parameter int unsigned ADDR_W = IFU_ADDR_W,
  parameter int unsigned DATA_W = IFU_DATA_W
);

  logic              ifu_rd_req;
  logic [ADDR_W-1:0] ifu_rd_addr;
  logic [DATA_W-1:0] ifu_rd_data;
  logic              dec_valid;
  logic              dec_ready;
  logic [DATA_W-1:0] dec_instr;
  logic [ADDR_W-1:0] dec_pc;
  logic [2:0]        dec_opcode;

  modport master (
    output ifu_rd_req,
    output ifu_rd_addr,
    input  ifu_rd_data,
    output dec_valid,
    input  dec_ready,
    output dec_instr,
    output dec_pc,
    output dec_opcode
  );

  modport slave (
    input  ifu_rd_req,
    input  ifu_rd_addr,
    output ifu_rd_data,
    input  dec_valid,
    output dec_ready,
    input  dec_instr,
    input  dec_pc,
    input  dec_opcode
  );

endinterface

// File: rtl/ifu_fetch_fifo.sv
// ifu_fetch_fifo: synchronous prefetch queue of fetch entries.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_flush        : clears the queue; dominates push and pop
//   i_push/i_data  : enqueue one entry
//   i_pop          : dequeue the head (ignored when empty)
//   o_head         : head entry, o_empty / o_count : occupancy
// Push and pop in the same cycle are legal at any occupancy.
module ifu_fetch_fifo
  import ifu_pkg::*;
#(
  parameter type         entry_t = fetch_entry_t,
  parameter int unsigned DEPTH   = 4,
  localparam int unsigned PtrW   = $clog2(DEPTH),
  localparam int unsigned CntW   = PtrW + 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_push,
  input  entry_t          i_data,
  input  logic            i_pop,
  output entry_t          o_head,
  output logic            o_empty,
  output logic [CntW-1:0] o_count
);

  entry_t            r_mem [DEPTH];
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [CntW-1:0]   r_count;
  logic              w_do_pop;
  logic              w_do_push;

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && i_rst_n && !i_flush;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      r_count <= r_count + CntW'(w_do_push) - CntW'(w_do_pop);
    end
  end

  // Storage needs no reset: entries are only visible through r_count.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  // The issue credit rule must make a full-queue push without a pop impossible.
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n || i_flush)
    !(i_push && !w_do_pop && r_count == CntW'(DEPTH)));

endmodule

// File: rtl/ifu_fetch_engine.sv
// ifu_fetch_engine: instruction prefetcher between memory and decode.
//   clk, rst_n      : clock, synchronous active-low reset
//   redirect_valid  : flush queue and in-flight word, restart at redirect_pc
//   redirect_pc     : new fetch address
//   fetch_halt      : stop issuing requests; in-flight data still lands
//   bus (master)    : memory read bus and decode valid/ready handshake
// Requests are issued only while a queue slot is guaranteed for the reply,
// counting the word already in flight.
module ifu_fetch_engine
  import ifu_pkg::*;
#(
  parameter int unsigned       ADDR_W     = IFU_ADDR_W,
  parameter int unsigned       DATA_W     = IFU_DATA_W,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              fetch_halt,
  ifu_fetch_engine_if.master bus
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_word_t;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic              r_inflight;
  fetch_state_e      r_state;
  fetch_state_e      w_state_next;

  logic [CntW-1:0]   w_count;
  logic [CntW-1:0]   w_count_after;
  logic [CntW-1:0]   w_owed;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  fetch_word_t       w_head;
  fetch_word_t       w_push_entry;

  // A redirect voids any pop in its cycle.
  assign w_pop         = !w_empty && bus.dec_ready && !redirect_valid;
  assign w_count_after = w_count - CntW'(w_pop);
  // Words held after this cycle's pop plus the one still owed by memory.
  assign w_owed        = w_count_after + CntW'(r_inflight);
  assign w_issue       = rst_n && !fetch_halt && !redirect_valid && (w_owed < DepthC);
  assign w_push        = r_inflight && !redirect_valid;
  assign w_push_entry  = '{pc: r_inflight_pc, instr: bus.ifu_rd_data};

  ifu_fetch_fifo #(
    .entry_t (fetch_word_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_state_next = StRun;
    if (redirect_valid) begin
      w_state_next = StRedirBubble;
    end else if (fetch_halt) begin
      w_state_next = StHalted;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= StRun;
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_state <= w_state_next;
      if (redirect_valid) begin
        r_pc       <= redirect_pc;
        r_inflight <= 1'b0;
      end else begin
        r_inflight <= w_issue;
        if (w_issue) begin
          r_pc          <= r_pc + ADDR_W'(1);
          r_inflight_pc <= r_pc;
        end
      end
    end
  end

  assign bus.ifu_rd_req  = w_issue;
  assign bus.ifu_rd_addr = rst_n ? r_pc : '0;
  assign bus.dec_valid   = !w_empty;
  assign bus.dec_instr   = w_empty ? '0 : w_head.instr;
  assign bus.dec_pc      = w_empty ? '0 : w_head.pc;
  assign bus.dec_opcode  = bus.dec_instr[DATA_W-1 -: 3];

  // The cycle after a redirect starts from an empty queue with nothing owed.
  a_bubble_clean: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == StRedirBubble) |-> (w_count == '0 && !r_inflight));

endmodule

// File: tb/tb_ifu_fetch_engine.sv
module tb_ifu_fetch_engine;
  import ifu_pkg::*;

  localparam int Depth = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [11:0] redirect_pc;
  logic        fetch_halt;

  ifu_fetch_engine_if #(.ADDR_W(12), .DATA_W(12)) bus ();

  ifu_fetch_engine #(
    .ADDR_W     (12),
    .DATA_W     (12),
    .FIFO_DEPTH (Depth),
    .RESET_PC   (12'o200)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_halt     (fetch_halt),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  // Memory: fixed 1-cycle latency; junk on the data bus when not requested.
  logic [11:0] mem [4096];
  always @(posedge clk) bus.ifu_rd_data <= bus.ifu_rd_req ? mem[bus.ifu_rd_addr] : 12'($urandom);

  int n_vec = 0;
  int n_err = 0;

  function automatic void check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0o, expected %0o (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: the fetch stream is consecutive addresses from the last
  // reset/redirect point. occ = words held in the queue plus the word owed.
  int           occ = 0;
  bit           infl = 0;
  logic [11:0]  nreq = 12'o200;
  fetch_entry_t q[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      check("req_in_reset", int'(bus.ifu_rd_req), 0);
      occ = 0; infl = 0; q.delete(); nreq = 12'o200;
    end else begin
      automatic bit exp_valid = (occ - int'(infl)) > 0;
      automatic bit exp_req;
      check("dec_valid", int'(bus.dec_valid), int'(exp_valid));
      if (exp_valid && bus.dec_valid) begin
        if (q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL model_queue: got empty queue, expected an entry (t=%0t)", $time);
        end else begin
          check("dec_pc", int'(bus.dec_pc), int'(q[0].pc));
          check("dec_instr", int'(bus.dec_instr), int'(q[0].instr));
          check("dec_opcode", int'(bus.dec_opcode), int'(q[0].instr[11:9]));
        end
      end
      if (redirect_valid) begin
        check("req_on_redirect", int'(bus.ifu_rd_req), 0);
        occ = 0; infl = 0; q.delete(); nreq = redirect_pc;
      end else begin
        if (exp_valid && bus.dec_ready) begin
          if (q.size() > 0) void'(q.pop_front());
          occ--;
        end
        exp_req = !fetch_halt && (occ < Depth);
        check("rd_req", int'(bus.ifu_rd_req), int'(exp_req));
        if (exp_req && bus.ifu_rd_req) check("rd_addr", int'(bus.ifu_rd_addr), int'(nreq));
        if (exp_req) begin
          q.push_back('{pc: nreq, instr: mem[nreq]});
          occ++;
          nreq++;
        end
        infl = exp_req;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          nreqs;
  logic [11:0] last_addr;
  logic [11:0] got [3];
  int          k;

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; fetch_halt = 1'b0;
    bus.dec_ready = 1'b0;
    for (int a = 0; a < 4096; a++) mem[a] = 12'(a + 1);

    // Reset state
    tick(); tick();
    @(negedge clk);
    check("rst_req", int'(bus.ifu_rd_req), 0);
    check("rst_addr", int'(bus.ifu_rd_addr), 0);
    check("rst_dec_valid", int'(bus.dec_valid), 0);
    check("rst_dec_instr", int'(bus.dec_instr), 0);
    check("rst_dec_pc", int'(bus.dec_pc), 0);

    // Streaming from reset with decode always ready
    tick(); rst_n = 1'b1; bus.dec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stream_req", int'(bus.ifu_rd_req), 1);
      check("stream_addr", int'(bus.ifu_rd_addr), 'o200 + i);
      if (i == 1) check("first_valid_early", int'(bus.dec_valid), 0);
      if (i == 2) begin
        check("first_valid", int'(bus.dec_valid), 1);
        check("first_pc", int'(bus.dec_pc), 'o200);
        check("first_instr", int'(bus.dec_instr), 'o201);
      end
    end

    // Backpressure: exactly FIFO_DEPTH requests, head held
    tick(); rst_n = 1'b0; bus.dec_ready = 1'b0;
    tick(); rst_n = 1'b1;
    nreqs = 0; last_addr = '0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      if (bus.ifu_rd_req) begin nreqs++; last_addr = bus.ifu_rd_addr; end
    end
    check("stall_req_count", nreqs, Depth);
    check("stall_last_addr", int'(last_addr), 'o203);
    check("stall_head_pc", int'(bus.dec_pc), 'o200);
    check("stall_head_instr", int'(bus.dec_instr), 'o201);
    tick(); bus.dec_ready = 1'b1;
    @(negedge clk);
    check("resume_req", int'(bus.ifu_rd_req), 1);
    check("resume_addr", int'(bus.ifu_rd_addr), 'o204);

    // Redirect near the top of memory: pc wraps
    tick(); redirect_valid = 1'b1; redirect_pc = 12'o7776;
    tick(); redirect_valid = 1'b0;
    k = 0;
    for (int c = 0; c < 20 && k < 3; c++) begin
      if (c > 0) tick();
      @(negedge clk);
      if (bus.dec_valid && bus.dec_ready) begin got[k] = bus.dec_pc; k++; end
    end
    check("wrap_handshakes", k, 3);
    check("wrap_pc0", int'(got[0]), 'o7776);
    check("wrap_pc1", int'(got[1]), 'o7777);
    check("wrap_pc2", int'(got[2]), 'o0000);

    // Redirect the cycle after the request to 'o205
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    check("pre_redir_addr", int'(bus.ifu_rd_addr), 'o205);
    tick(); redirect_valid = 1'b1; redirect_pc = 12'o1234;
    @(negedge clk);
    check("redir_no_req", int'(bus.ifu_rd_req), 0);
    tick(); redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_req", int'(bus.ifu_rd_req), 1);
    check("redir_addr", int'(bus.ifu_rd_addr), 'o1234);
    check("redir_empty", int'(bus.dec_valid), 0);
    tick();
    @(negedge clk);
    check("redir_dropped", int'(bus.dec_valid), 0);
    tick();
    @(negedge clk);
    check("redir_valid", int'(bus.dec_valid), 1);
    check("redir_pc", int'(bus.dec_pc), 'o1234);

    // Halt with one request in flight
    tick(); rst_n = 1'b0; bus.dec_ready = 1'b0;
    tick(); rst_n = 1'b1;
    @(negedge clk);
    check("halt_pre_addr", int'(bus.ifu_rd_addr), 'o200);
    tick(); fetch_halt = 1'b1;
    @(negedge clk);
    check("halt_no_req", int'(bus.ifu_rd_req), 0);
    tick();
    @(negedge clk);
    check("halt_landed", int'(bus.dec_valid), 1);
    check("halt_landed_pc", int'(bus.dec_pc), 'o200);
    tick(); tick();
    @(negedge clk);
    check("halt_still_quiet", int'(bus.ifu_rd_req), 0);
    tick(); fetch_halt = 1'b0;
    @(negedge clk);
    check("unhalt_req", int'(bus.ifu_rd_req), 1);
    check("unhalt_addr", int'(bus.ifu_rd_addr), 'o201);

    // Reset with a loaded queue and a word in flight
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    repeat (4) tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    @(negedge clk);
    check("mrst_valid", int'(bus.dec_valid), 0);
    check("mrst_addr", int'(bus.ifu_rd_addr), 'o200);
    tick();
    @(negedge clk);
    check("mrst_stale_dropped", int'(bus.dec_valid), 0);
    tick();
    @(negedge clk);
    check("mrst_first_pc", int'(bus.dec_pc), 'o200);

    // Randomized traffic against the model
    tick(); rst_n = 1'b0;
    for (int a = 0; a < 4096; a++) mem[a] = 12'($urandom);
    tick(); rst_n = 1'b1;
    repeat (2000) begin
      tick();
      bus.dec_ready  = ($urandom_range(0, 9) < 7);
      fetch_halt     = ($urandom_range(0, 9) == 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 12'(12'o7775 + $urandom_range(0, 2))
                                                   : 12'($urandom);
      rst_n          = ($urandom_range(0, 99) != 0);
    end
    tick(); redirect_valid = 1'b0; rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
